// File: rtl/bcd2int_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd2int_pkg
// Description : Shared types and constants for the BCD-to-binary arbiter
//               slice: FSM state encoding, largest legal BCD digit, result
//               width and default requester-count parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd2int_pkg;

    localparam int NREQ_DEF = 4;
    localparam int IDW_DEF  = 2;
    localparam int RES_W    = 7;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : bcd2int_pkg
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin picker. Finds the first set bit of
//               req searching upward from rr_ptr, wrapping past NREQ-1.
// Ports       : req       - request vector
//               rr_ptr    - index with highest priority this round
//               gnt_valid - at least one request present
//               gnt_id    - index of the chosen requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic            gnt_valid,
    output logic [IDW-1:0]  gnt_id
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest set bit (offset 0
    // = rr_ptr itself) is the last assignment and therefore wins.
    always_comb begin
        gnt_valid = |req;
        gnt_id    = '0;
        idx       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (req[idx]) begin
                gnt_id = IDW'(idx);
            end
        end
    end

endmodule : rr_picker
`default_nettype wire

// File: rtl/bcd2int_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bcd2int_arbiter
// Description : Shares one external combinational two-digit BCD-to-binary
//               converter among NREQ requesters. Round-robin grant, one
//               transaction at a time: latch digits, convert, register the
//               result, pulse ack/out_valid. Digits above 9 flag out_err.
// Ports       : clk, rst_n           - clock, async active-low reset
//               req                  - per-requester request level
//               bcd_h_in / bcd_l_in  - packed digits, requester i at [4i+:4]
//               ack                  - one-cycle ack to served requester
//               out_valid            - one-cycle result-valid pulse
//               out_id/out_data/out_err - result fields, held between pulses
//               conv_h / conv_l      - digits driven to the shared converter
//               conv_data            - converter result
// Revision    : 1.0 - initial release
// ============================================================================
module bcd2int_arbiter
    import bcd2int_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = IDW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [4*NREQ-1:0]   bcd_h_in,
    input  logic [4*NREQ-1:0]   bcd_l_in,
    output logic [NREQ-1:0]     ack,
    output logic                out_valid,
    output logic [IDW-1:0]      out_id,
    output logic [RES_W-1:0]    out_data,
    output logic                out_err,
    output logic [3:0]          conv_h,
    output logic [3:0]          conv_l,
    input  logic [RES_W-1:0]    conv_data
);

    state_t             state_q,     state_d;
    logic [IDW-1:0]     rr_ptr_q,    rr_ptr_d;
    logic [IDW-1:0]     id_q,        id_d;
    logic [3:0]         conv_h_q,    conv_h_d;
    logic [3:0]         conv_l_q,    conv_l_d;
    logic [IDW-1:0]     out_id_q,    out_id_d;
    logic [RES_W-1:0]   out_data_q,  out_data_d;
    logic               out_err_q,   out_err_d;
    logic [NREQ-1:0]    ack_q,       ack_d;
    logic               out_valid_q, out_valid_d;

    logic               gnt_valid;
    logic [IDW-1:0]     gnt_id;
    logic [3:0]         sel_h;
    logic [3:0]         sel_l;
    logic               digit_err;

    rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_picker (
        .req       (req),
        .rr_ptr    (rr_ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Digit mux for the granted requester.
    always_comb begin
        sel_h = 4'd0;
        sel_l = 4'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                sel_h = bcd_h_in[4*i +: 4];
                sel_l = bcd_l_in[4*i +: 4];
            end
        end
    end

    assign digit_err = (conv_h_q > BCD_MAX) || (conv_l_q > BCD_MAX);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        conv_h_d    = conv_h_q;
        conv_l_d    = conv_l_q;
        out_id_d    = out_id_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        ack_d       = '0;
        out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    id_d     = gnt_id;
                    conv_h_d = sel_h;
                    conv_l_d = sel_l;
                    state_d  = CONV;
                end
            end
            CONV: begin
                // Result and handshake are registered here so they appear
                // together during DONE.
                out_id_d    = id_q;
                out_err_d   = digit_err;
                out_data_d  = digit_err ? '0 : conv_data;
                rr_ptr_d    = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
                ack_d       = {{(NREQ-1){1'b0}}, 1'b1} << id_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            conv_h_q    <= 4'd0;
            conv_l_q    <= 4'd0;
            out_id_q    <= '0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            ack_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            conv_h_q    <= conv_h_d;
            conv_l_q    <= conv_l_d;
            out_id_q    <= out_id_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            ack_q       <= ack_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign ack       = ack_q;
    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign conv_h    = conv_h_q;
    assign conv_l    = conv_l_q;

endmodule : bcd2int_arbiter
`default_nettype wire

// File: tb/tb_bcd2int_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd2int_arbiter
// Description : Scoreboard bench for bcd2int_arbiter. Stimulus pushes the
//               hand-computed expected result; a monitor pops and compares
//               on every out_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd2int_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [4*NREQ-1:0]   bcd_h_in;
    logic [4*NREQ-1:0]   bcd_l_in;
    logic [NREQ-1:0]     ack;
    logic                out_valid;
    logic [IDW-1:0]      out_id;
    logic [6:0]          out_data;
    logic                out_err;
    logic [3:0]          conv_h;
    logic [3:0]          conv_l;
    logic [6:0]          conv_data;

    typedef struct {
        int id;
        int data;
        int err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    bcd2int_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .bcd_h_in  (bcd_h_in),
        .bcd_l_in  (bcd_l_in),
        .ack       (ack),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_data  (out_data),
        .out_err   (out_err),
        .conv_h    (conv_h),
        .conv_l    (conv_l),
        .conv_data (conv_data)
    );

    // Behavioural stand-in for the external converter.
    always_comb begin
        conv_data = 7'((int'(conv_h) * 10 + int'(conv_l)) % 128);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int id, input int data, input int err);
        exp_t e;
        e.id   = id;
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic set_dig(input int i, input int h, input int l);
        bcd_h_in[4*i +: 4] = 4'(h);
        bcd_l_in[4*i +: 4] = 4'(l);
    endtask

    // Returns at the negedge where out_valid is seen, or after maxc negedges.
    task automatic wait_valid(input string name, input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < maxc);
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no out_valid within %0d cycles", name, maxc);
        end
    endtask

    // Monitor: scoreboard comparison on every result pulse; ack idle otherwise.
    initial begin
        exp_t e;
        logic [NREQ-1:0] exp_ack;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_valid: out_id %0d with empty scoreboard", out_id);
                    end else begin
                        e = sb.pop_front();
                        exp_ack = 4'b0001 << e.id;
                        chk("out_id",   int'(out_id),   e.id);
                        chk("out_data", int'(out_data), e.data);
                        chk("out_err",  int'(out_err),  e.err);
                        chk("ack",      int'(ack),      int'(exp_ack));
                    end
                end else begin
                    chk("ack_idle", int'(ack), 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;

        rst_n    = 1'b0;
        req      = '0;
        bcd_h_in = '0;
        bcd_l_in = '0;
        repeat (2) @(negedge clk);

        // ---- Test 1: reset while converting ----
        rst_n = 1'b1;
        req   = 4'b0100;
        set_dig(2, 3, 5);
        @(posedge clk);              // grant edge -> CONV
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ack",       int'(ack),       0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data",  int'(out_data),  0);
        chk("rst_out_id",    int'(out_id),    0);
        chk("rst_out_err",   int'(out_err),   0);
        chk("rst_conv_h",    int'(conv_h),    0);
        chk("rst_conv_l",    int'(conv_l),    0);
        @(negedge clk);
        push(2, 35, 0);
        rst_n = 1'b1;
        wait_valid("t1", 3, n);
        chk("t1_latency_le3", int'(n <= 3), 1);
        req = '0;

        // ---- Test 2: single request ----
        @(negedge clk);
        req = 4'b0010;
        set_dig(1, 4, 7);
        push(1, 47, 0);
        wait_valid("t2", 4, n);
        chk("t2_latency", n, 2);
        req = '0;

        // ---- Test 3: all requesters from reset, round-robin order ----
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b1111;
        set_dig(0, 1, 1);
        set_dig(1, 2, 3);
        set_dig(2, 3, 5);
        set_dig(3, 4, 7);
        push(0, 11, 0);
        push(1, 23, 0);
        push(2, 35, 0);
        push(3, 47, 0);
        push(0, 11, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid("t3_first", 4, n);
        chk("t3_first_latency", n, 2);
        for (int k = 1; k < 5; k++) begin
            wait_valid("t3_next", 5, n);
            chk("t3_period", n, 3);
        end
        req = '0;

        // ---- Test 4: invalid digit ----
        @(negedge clk);
        req = 4'b1000;
        set_dig(3, 10, 2);
        push(3, 0, 1);
        wait_valid("t4", 4, n);
        chk("t4_conv_h", int'(conv_h), 10);
        req = '0;

        // ---- Test 5: digits change after grant; clears out_err ----
        @(negedge clk);
        req = 4'b0001;
        set_dig(0, 9, 9);
        push(0, 99, 0);
        @(posedge clk);              // grant edge
        @(negedge clk);              // mid-CONV
        set_dig(0, 1, 1);
        wait_valid("t5", 3, n);
        req = '0;

        // ---- Test 6: request pulse during DONE is ignored ----
        @(negedge clk);
        req = 4'b0001;
        set_dig(0, 2, 0);
        set_dig(2, 7, 7);
        push(0, 20, 0);
        wait_valid("t6", 4, n);
        req = 4'b0100;               // high only across the DONE->IDLE edge
        @(posedge clk);
        #1 req = '0;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("t6_no_valid", cnt, 0);
        chk("t6_conv_h",   int'(conv_h), 2);
        chk("t6_conv_l",   int'(conv_l), 0);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bcd2int_arbiter
`default_nettype wire
